// File: rtl/timing_sequencer.sv
// rtl/timing_sequencer.sv - sequence counter, IR and S/R/IEN flags with T/D/I/B decode
module timing_sequencer #(
  parameter int SC_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      INR_SC,
  input  logic                      CLR_SC,
  input  logic                      LD_IR,
  input  logic [15:0]               IR_in,
  input  logic                      Set_S,
  input  logic                      Clear_S,
  input  logic                      Set_R,
  input  logic                      Clear_R,
  input  logic                      Set_IEN,
  input  logic                      Clear_IEN,
  output logic [SC_WIDTH-1:0]       SC,
  output logic [(1<<SC_WIDTH)-1:0]  T,
  output logic [7:0]                D,
  output logic                      I,
  output logic [11:0]               B,
  output logic                      S,
  output logic                      R,
  output logic                      IEN
);

  localparam int T_WIDTH = 1 << SC_WIDTH;

  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic [15:0]         ir_q, ir_d;
  logic                s_q, s_d;
  logic                r_q, r_d;
  logic                ien_q, ien_d;

  // Next-state rules; each register is independent and every clear beats its set.
  // The counter gates on the pre-edge S, so Start only enables counting from the next cycle.
  always_comb begin
    sc_d  = sc_q;
    ir_d  = ir_q;
    s_d   = s_q;
    r_d   = r_q;
    ien_d = ien_q;

    if (CLR_SC) begin
      sc_d = '0;
    end else if (INR_SC && s_q) begin
      sc_d = sc_q + SC_WIDTH'(1);
    end

    if (LD_IR) begin
      ir_d = IR_in;
    end

    if (Start || Set_S) s_d = 1'b1;
    if (Clear_S)        s_d = 1'b0;

    if (Set_R)          r_d = 1'b1;
    if (Clear_R)        r_d = 1'b0;

    if (Set_IEN)        ien_d = 1'b1;
    if (Clear_IEN)      ien_d = 1'b0;
  end

  // State registers; reset overrides every control, even mid-instruction.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sc_q  <= '0;
      ir_q  <= '0;
      s_q   <= 1'b0;
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      ir_q  <= ir_d;
      s_q   <= s_d;
      r_q   <= r_d;
      ien_q <= ien_d;
    end
  end

  // Timing and opcode decodes straight off registered state, no extra stage.
  always_comb begin
    T = '0;
    T[sc_q] = 1'b1;
    D = '0;
    D[ir_q[14:12]] = 1'b1;
  end

  assign SC  = sc_q;
  assign I   = ir_q[15];
  assign B   = ir_q[11:0];
  assign S   = s_q;
  assign R   = r_q;
  assign IEN = ien_q;

  logic unused_t_width;
  assign unused_t_width = (T_WIDTH == 0);

endmodule

// File: tb/tb_timing_sequencer.sv
// tb/tb_timing_sequencer.sv - scoreboard bench for timing_sequencer
module tb_timing_sequencer;

  logic        clk = 1'b0;
  logic        Reset, Start, INR_SC, CLR_SC, LD_IR;
  logic [15:0] IR_in;
  logic        Set_S, Clear_S, Set_R, Clear_R, Set_IEN, Clear_IEN;
  logic [3:0]  SC;
  logic [15:0] T;
  logic [7:0]  D;
  logic        I;
  logic [11:0] B;
  logic        S, R, IEN;

  int passed = 0;
  int total  = 0;

  logic [43:0] sb_q[$];
  string       nm_q[$];
  logic [43:0] exp_v;
  string       nm;
  logic [15:0] cur_ir;

  timing_sequencer #(.SC_WIDTH(4)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .INR_SC(INR_SC), .CLR_SC(CLR_SC),
    .LD_IR(LD_IR), .IR_in(IR_in), .Set_S(Set_S), .Clear_S(Clear_S),
    .Set_R(Set_R), .Clear_R(Clear_R), .Set_IEN(Set_IEN), .Clear_IEN(Clear_IEN),
    .SC(SC), .T(T), .D(D), .I(I), .B(B), .S(S), .R(R), .IEN(IEN)
  );

  always #5 clk = ~clk;

  wire [43:0] obs = {T, D, I, B, S, R, IEN, SC};

  function automatic logic [43:0] mk(input logic [3:0] sc, input logic [15:0] ir,
                                     input logic s, input logic r, input logic ien);
    logic [15:0] t;
    logic [7:0]  d;
    t = 16'h0001 << sc;
    d = 8'h01 << ir[14:12];
    return {t, d, ir[15], ir[11:0], s, r, ien, sc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Reset = 0; Start = 0; INR_SC = 0; CLR_SC = 0; LD_IR = 0;
    Set_S = 0; Clear_S = 0; Set_R = 0; Clear_R = 0; Set_IEN = 0; Clear_IEN = 0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1; LD_IR = 1; IR_in = 16'hFFFF; Set_R = 1; Set_IEN = 1; Start = 1;
    tick();
    sb_q.push_back(mk(4'd0, 16'h0000, 0, 0, 0)); nm_q.push_back("reset");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    total++;
    if ({T, D} !== {16'h0001, 8'h01}) $display("FAIL reset_decode: got %h want %h", {T, D}, {16'h0001, 8'h01});
    else passed++;
    idle();
    cur_ir = 16'h0000;
    INR_SC = 1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(mk(4'd0, cur_ir, 0, 0, 0)); nm_q.push_back("halted_inr");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    idle();
  endtask

  task automatic test_count();
    idle();
    Start = 1; INR_SC = 1;
    sb_q.push_back(mk(4'd0, cur_ir, 1, 0, 0)); nm_q.push_back("start_holds_sc");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    Start = 0;
    for (int k = 1; k <= 16; k++) begin
      sb_q.push_back(mk(4'(k), cur_ir, 1, 0, 0)); nm_q.push_back($sformatf("count_%0d", k));
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
      if (k == 3) begin
        total++;
        if (T !== 16'h0008) $display("FAIL t_after_3: got %h want %h", T, 16'h0008); else passed++;
      end
    end
    total++;
    if (T !== 16'h0001) $display("FAIL t_wrap: got %h want %h", T, 16'h0001); else passed++;
    idle();
  endtask

  task automatic test_clr();
    idle();
    INR_SC = 1;
    for (int k = 1; k <= 5; k++) begin
      sb_q.push_back(mk(4'(k), cur_ir, 1, 0, 0)); nm_q.push_back("run_to_t5");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    CLR_SC = 1;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(mk(4'd0, cur_ir, 1, 0, 0)); nm_q.push_back(k == 0 ? "clr_over_inr" : "clr_back_to_back");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    idle();
  endtask

  task automatic test_ir();
    idle();
    LD_IR = 1; IR_in = 16'hB7C4;
    cur_ir = 16'hB7C4;
    sb_q.push_back(mk(4'd0, cur_ir, 1, 0, 0)); nm_q.push_back("ld_ir");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    total++;
    if ({I, D, B} !== {1'b1, 8'h08, 12'h7C4})
      $display("FAIL ir_decode: got %h want %h", {I, D, B}, {1'b1, 8'h08, 12'h7C4});
    else passed++;
    LD_IR = 0; IR_in = 16'h0000;
    sb_q.push_back(mk(4'd0, cur_ir, 1, 0, 0)); nm_q.push_back("ir_hold");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
  endtask

  task automatic test_halt();
    idle();
    INR_SC = 1;
    for (int k = 1; k <= 2; k++) begin
      sb_q.push_back(mk(4'(k), cur_ir, 1, 0, 0)); nm_q.push_back("run_to_t2");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    Clear_S = 1;
    sb_q.push_back(mk(4'd3, cur_ir, 0, 0, 0)); nm_q.push_back("hlt_with_inr");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    Clear_S = 0;
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(mk(4'd3, cur_ir, 0, 0, 0)); nm_q.push_back("frozen_t3");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    total++;
    if (T !== 16'h0008) $display("FAIL frozen_t: got %h want %h", T, 16'h0008); else passed++;
    idle();
  endtask

  task automatic test_flags();
    idle();
    Set_R = 1; Clear_R = 1; Set_S = 1; Clear_S = 1;
    sb_q.push_back(mk(4'd3, cur_ir, 0, 0, 0)); nm_q.push_back("clear_beats_set");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
    Set_IEN = 1;
    sb_q.push_back(mk(4'd3, cur_ir, 0, 0, 1)); nm_q.push_back("set_ien");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
    Set_R = 1; Start = 1;
    sb_q.push_back(mk(4'd3, cur_ir, 1, 1, 1)); nm_q.push_back("set_r_start");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
    CLR_SC = 1;
    sb_q.push_back(mk(4'd0, cur_ir, 1, 1, 1)); nm_q.push_back("clr_to_t0");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
    INR_SC = 1;
    for (int k = 1; k <= 5; k++) begin
      sb_q.push_back(mk(4'(k), cur_ir, 1, 1, 1)); nm_q.push_back("run_to_t5_flags");
      tick();
      exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    end
    Reset = 1; Set_R = 1; Set_IEN = 1; Start = 1; LD_IR = 1; IR_in = 16'h7FFF;
    cur_ir = 16'h0000;
    sb_q.push_back(mk(4'd0, cur_ir, 0, 0, 0)); nm_q.push_back("reset_mid_instr");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
    INR_SC = 1;
    sb_q.push_back(mk(4'd0, cur_ir, 0, 0, 0)); nm_q.push_back("halted_after_reset");
    tick();
    exp_v = sb_q.pop_front(); nm = nm_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL %s: got %h want %h", nm, obs, exp_v); else passed++;
    idle();
  endtask

  initial begin
    idle();
    IR_in = 16'h0000;
    cur_ir = 16'h0000;
    test_reset();
    test_count();
    test_clr();
    test_ir();
    test_halt();
    test_flags();
    total++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", sb_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Sequencing front end for the basic-computer control unit. Holds the 4-bit sequence counter (SC), the instruction register (IR) and the start/stop (S), interrupt (R) and interrupt-enable (IEN) flip-flops. Decodes them into the one-hot timing vector T, the opcode vector D, the indirect bit I and the address/register field B that the control unit consumes. Acts on the control unit's CLR_SC / INR_SC / LD_IR / Set_* / Clear_* outputs, closing the fetch–decode–execute loop.

## Interface
Parameters:
- SC_WIDTH, 4, sequence counter width; T width is 2**SC_WIDTH (16)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; sets S
- INR_SC  in  1  increment SC (only when S=1)
- CLR_SC  in  1  clear SC to 0
- LD_IR  in  1  load IR from IR_in
- IR_in  in  16  common-bus value to load into IR
- Set_S, Clear_S  in  1 each  S flip-flop control (Clear_S = HLT)
- Set_R, Clear_R  in  1 each  interrupt flip-flop control
- Set_IEN, Clear_IEN  in  1 each  interrupt-enable control
- SC  out  4  current sequence count
- T  out  16  one-hot decode of SC, T[SC]=1
- D  out  8  one-hot decode of IR[14:12]
- I  out  1  IR[15]
- B  out  12  IR[11:0]
- S, R, IEN  out  1 each  flip-flop states

## Operation
- Registers: SC[3:0], IR[15:0], S, R, IEN. T, D, I, B are pure combinational decodes of registered state; no extra pipeline stage.
- SC update, in priority order:
  - Reset: SC=0.
  - CLR_SC=1: SC=0, regardless of S and INR_SC.
  - INR_SC=1 and S=1: SC=SC+1 mod 16; 15 wraps to 0.
  - Otherwise SC holds. With S=0, INR_SC is ignored and T stays frozen.
- S uses the pre-edge value. INR_SC and Clear_S in the same cycle: the increment happens, and S=0 from the next cycle.
- IR: loads IR_in on LD_IR=1, otherwise holds. D[k]=1 iff IR[14:12]=k; exactly one D bit is always high.
- S flip-flop:
  - Set by Start or Set_S.
  - Cleared by Clear_S; clear wins over set.
- R flip-flop: Set_R sets, Clear_R clears; clear wins over set.
- IEN flip-flop: Set_IEN sets, Clear_IEN clears; clear wins over set.
- All register updates are independent. Any combination of controls in one cycle is legal, and each register follows its own rule.
- Reset values: SC=0, T=16'h0001, IR=0, D=8'h01, I=0, B=12'h000, S=0, R=0, IEN=0.
- Reset has priority over every other input, including mid-instruction (e.g. at T5). SC returns to T0 on the next edge and the machine stays halted until Start.

## Timing
- All outputs update one clock after the triggering control: SC/T one edge after INR_SC/CLR_SC, D/I/B one edge after LD_IR, flags one edge after Set_*/Clear_*/Start.
- No combinational path from any input to any output; every output is a function of registered state only.
- Typical fetch, with the control unit asserting INR_SC every cycle while S=1:
  - T0 → T1: LD_IR pulse.
  - T1 → T2: D, I, B valid from T2.
- A CLR_SC seen in cycle Tn gives T0 in the next cycle. There is no minimum spacing between CLR_SC pulses.
- Start and INR_SC in the same cycle while S=0: SC holds this cycle and counting begins the following cycle.

## Test plan
- Reset held 2 cycles → SC=0, T=16'h0001, D=8'h01, I=0, B=0, S=R=IEN=0. With INR_SC=1 and S=0 for 3 cycles, T stays 16'h0001.
- Start pulse, then INR_SC=1 for 3 cycles → T=16'h0008. Continue to 16 total increments → T wraps to 16'h0001.
- At T=16'h0020, assert CLR_SC and INR_SC together → next cycle T=16'h0001.
- LD_IR with IR_in=16'hB7C4 → next cycle I=1, D=8'h08, B=12'h7C4. IR then holds while LD_IR=0 and IR_in changes to 16'h0000.
- While running at T=16'h0004, assert Clear_S with INR_SC → T=16'h0008 and S=0, then frozen at 16'h0008 for 4 further INR_SC cycles.
- Flag controls:
  - Set_R and Clear_R together → R=0.
  - Set_IEN alone → IEN=1.
  - Reset asserted at T=16'h0020 with IEN=1, R=1 → next cycle all reset values restored.
